// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester front end for a shared combinational 8-bit ALU.
//            One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
//            Optional feature macro ALU_ARB_RR_EN selects round-robin
//            arbitration; when undefined, req0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  // requester 0
  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic [3:0] req0_func_i,
  input  logic [7:0] req0_a_i,
  input  logic [7:0] req0_b_i,
  // requester 1
  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic [3:0] req1_func_i,
  input  logic [7:0] req1_a_i,
  input  logic [7:0] req1_b_i,
  // ALU side
  output logic [3:0] alu_func_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  input  logic [7:0] alu_res_i,
  input  logic       alu_zf_i,
  input  logic       alu_of_i,
  input  logic       alu_cf_i,
  input  logic       alu_sf_i,
  // response
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [7:0] rsp_res_o,
  output logic [3:0] rsp_flags_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] alu_func_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [7:0] rsp_res_q;
  logic [3:0] rsp_flags_q;
`ifdef ALU_ARB_RR_EN
  logic       last_grant_q;
`endif

  logic       grant_d;
  logic       w_any_valid;
  logic       w_handshake;
  logic       w_flag_upd;
  logic [3:0] w_sel_func;
  logic [7:0] w_sel_a;
  logic [7:0] w_sel_b;

  assign w_any_valid = req0_valid_i | req1_valid_i;
  assign w_handshake = (state_q == S_IDLE) && w_any_valid;

  // Arbitration: a lone requester always wins; contention resolved by policy.
  always_comb begin
    grant_d = 1'b0;
    if (req1_valid_i && !req0_valid_i) begin
      grant_d = 1'b1;
    end else if (req1_valid_i && req0_valid_i) begin
`ifdef ALU_ARB_RR_EN
      grant_d = ~last_grant_q;
`else
      grant_d = 1'b0;
`endif
    end
  end

  // Ready is offered only in IDLE and only to the granted requester.
  assign req0_ready_o = (state_q == S_IDLE) && req0_valid_i && !grant_d;
  assign req1_ready_o = (state_q == S_IDLE) && req1_valid_i &&  grant_d;

  assign w_sel_func = grant_d ? req1_func_i : req0_func_i;
  assign w_sel_a    = grant_d ? req1_a_i    : req0_a_i;
  assign w_sel_b    = grant_d ? req1_b_i    : req0_b_i;

  // No-op (0), pass-B (6) and pass-A (8) leave the flag register untouched.
  always_comb begin
    w_flag_upd = 1'b1;
    case (alu_func_q)
      4'd0, 4'd6, 4'd8: w_flag_upd = 1'b0;
      default:          w_flag_upd = 1'b1;
    endcase
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      alu_func_q   <= 4'd0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= 8'h00;
      rsp_flags_q  <= 4'b0000;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_handshake) begin
            alu_func_q   <= w_sel_func;
            alu_a_q      <= w_sel_a;
            alu_b_q      <= w_sel_b;
            rsp_id_q     <= grant_d;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= grant_d;
`endif
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_res_q <= alu_res_i;
          if (w_flag_upd) begin
            rsp_flags_q <= {alu_zf_i, alu_of_i, alu_cf_i, alu_sf_i};
          end
          // ALU goes back to no-op; operands are kept.
          alu_func_q  <= 4'd0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          alu_func_q  <= 4'd0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_func_o  = alu_func_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_res_o   = rsp_res_q;
  assign rsp_flags_o = rsp_flags_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  async active-low reset.
REQ-002 SHALL have, for k in {0,1}: reqk_valid in 1, reqk_ready out 1, reqk_func in 4, reqk_a in 8, reqk_b in 8 (requester k operation: ALU func code, operands).
REQ-003 SHALL have ALU-side ports: alu_func out 4, alu_a out 8, alu_b out 8, alu_res in 8, alu_zf/alu_of/alu_cf/alu_sf in 1 each (combinational 8-bit ALU, func codes 0-15).
REQ-004 SHALL have response ports: rsp_valid out 1, rsp_ready in 1, rsp_id out 1 (granted requester), rsp_res out 8, rsp_flags out 4 ordered {zf,of,cf,sf}, busy out 1 (state != IDLE).

Function
REQ-005 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-006 IDLE: reqk_ready asserted combinationally only for the granted requester when at least one reqk_valid=1; handshake = valid&ready; on handshake, latch func/a/b into alu_func/alu_a/alu_b, latch grant into rsp_id, go EXEC.
REQ-007 Requesters SHALL hold func/a/b stable while valid and not ready; the block SHALL NOT sample them outside the handshake cycle.
REQ-008 EXEC (exactly one cycle): capture alu_res into rsp_res; go RESP with rsp_valid=1 next cycle.
REQ-009 Latency: handshake in cycle N -> rsp_valid=1 in cycle N+2; max throughput one op per 3 cycles.
REQ-010 RESP: hold rsp_valid, rsp_id, rsp_res, rsp_flags stable until rsp_valid&rsp_ready; then go IDLE; both reqk_ready=0 throughout RESP and EXEC.
REQ-011 Outside EXEC alu_func SHALL be 0 (no-op); alu_a/alu_b retain last latched values.
REQ-012 Flag register SHALL update from alu_* flags in EXEC only when func in {1,2,3,4,5,7,9..15}; for func 0, 6, 8 it SHALL retain its previous value; rsp_flags = flag register.
REQ-013 rsp_res for func 0 SHALL be 0x00 as returned by the ALU; no result transformation.
REQ-014 Arbitration (see REQ-018): grant to the only valid requester; when both valid, apply the configured policy; a request arriving during EXEC/RESP waits until IDLE.
REQ-015 Round-robin pointer last_grant SHALL update only on a request handshake.

Reset
REQ-016 On rst_n=0 (asynchronous, any state incl. mid-EXEC/RESP): state=IDLE, rsp_valid=0, rsp_id=0, rsp_res=0x00, rsp_flags=4'b0000, alu_func=0, alu_a=alu_b=0x00, last_grant=1, busy=0; in-flight op discarded, never responded.
REQ-017 After rst_n deassertion the first arbitration SHALL favour req0.

Configuration
REQ-018 Macro ALU_ARB_RR_EN: defined -> round-robin (both valid: grant the requester != last_grant); undefined -> fixed priority (both valid: req0 always wins), last_grant unused.

Verification
REQ-019 req0 func=2 a=0xF0 b=0x0F, rsp_ready=1 -> req0_ready in cycle N, rsp_valid in N+2, rsp_id=0, rsp_res=0x00, rsp_flags=4'b1000, back to IDLE N+3.
REQ-020 After REQ-019, req1 func=6 b=0x80 -> rsp_id=1, rsp_res=0x80, rsp_flags still 4'b1000 (retained).
REQ-021 req0 and req1 both held valid for 4 ops -> grants 0,1,0,1 with ALU_ARB_RR_EN; 0,0,0,0 without it.
REQ-022 rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, both reqk_ready=0, no acceptance; handshake on cycle 6 -> IDLE next cycle.
REQ-023 rst_n pulsed low during EXEC -> immediately all outputs at REQ-016 values; no rsp_valid for the dropped op; next request accepted normally.
